// File: rtl/router_fsm_ctrl.sv
// rtl/router_fsm_ctrl.sv - packet-sequencing FSM for the 1x3 router input side
//
// Decodes the header address, waits for the addressed output FIFO to drain,
// then sequences load-first-data, payload, FIFO-full stall and parity phases.
// Keeps saturating counts of dropped (address 2'b11) and soft-reset-aborted
// packets.
//
// Ports:
//   clock, resetn                 rising-edge clock, asynchronous active-low reset
//   pkt_valid                     packet valid (low on the parity byte)
//   data_in[1:0]                  header address, decoded in DECODE_ADDRESS
//   fifo_full                     full flag of the addressed FIFO
//   fifo_empty_0/1/2              empty flags of the three output FIFOs
//   soft_reset_0/1/2              per-FIFO read-timeout soft resets
//   parity_done, low_pkt_valid    status from the register block
//   detect_add .. rst_int_reg     Moore state strobes
//   busy                          high outside DECODE_ADDRESS and LOAD_DATA
//   drop_cnt, abort_cnt           saturating event counters
module router_fsm_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [1:0]       data_in,
    input  logic             fifo_full,
    input  logic             fifo_empty_0,
    input  logic             fifo_empty_1,
    input  logic             fifo_empty_2,
    input  logic             soft_reset_0,
    input  logic             soft_reset_1,
    input  logic             soft_reset_2,
    input  logic             parity_done,
    input  logic             low_pkt_valid,
    output logic             detect_add,
    output logic             lfd_state,
    output logic             ld_state,
    output logic             laf_state,
    output logic             full_state,
    output logic             write_enb_reg,
    output logic             rst_int_reg,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] addr_reg;
    logic       pkt_valid_d;
    logic       tgt_empty;
    logic       tgt_sr;
    logic       hdr_empty;
    logic       abort_inc;
    logic       drop_inc;

    // Flags of the FIFO latched at header time; address 3 has no FIFO.
    always_comb begin
        tgt_empty = 1'b0;
        tgt_sr    = 1'b0;
        case (addr_reg)
            2'd0:    begin tgt_empty = fifo_empty_0; tgt_sr = soft_reset_0; end
            2'd1:    begin tgt_empty = fifo_empty_1; tgt_sr = soft_reset_1; end
            2'd2:    begin tgt_empty = fifo_empty_2; tgt_sr = soft_reset_2; end
            default: begin tgt_empty = 1'b0;         tgt_sr = 1'b0;         end
        endcase
    end

    // The header decision itself cannot wait for addr_reg, so it looks at
    // the live address on data_in.
    always_comb begin
        hdr_empty = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // Rising edge of pkt_valid makes a held 2'b11 header count only once.
    assign drop_inc  = (state == DECODE_ADDRESS) && pkt_valid && !pkt_valid_d
                       && (data_in == 2'b11);
    assign abort_inc = (state != DECODE_ADDRESS) && tgt_sr;

    always_comb begin
        state_nxt = state;
        if (abort_inc) begin
            // Soft reset of the addressed FIFO overrides every other condition.
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'b11)
                        state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_nxt = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_nxt = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_nxt = LOAD_PARITY;
                    else                    state_nxt = LOAD_DATA;
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (tgt_empty) state_nxt = LOAD_FIRST_DATA;
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= DECODE_ADDRESS;
            addr_reg    <= 2'd0;
            pkt_valid_d <= 1'b0;
            drop_cnt    <= '0;
            abort_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            pkt_valid_d <= pkt_valid;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_reg <= data_in;
            if (drop_inc && drop_cnt != {CNT_W{1'b1}})
                drop_cnt <= drop_cnt + CNT_W'(1);
            if (abort_inc && abort_cnt != {CNT_W{1'b1}})
                abort_cnt <= abort_cnt + CNT_W'(1);
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY)
                           || (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb/tb_router_fsm_ctrl.sv - self-checking bench for router_fsm_ctrl
module tb_router_fsm_ctrl;

    typedef enum int {S_DA, S_LFD, S_LD, S_LP, S_FFS, S_LAF, S_CPE, S_WTE} tst_t;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        tst_t       st;
        int         drop;
        int         abort;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [7:0] drop_cnt, abort_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    router_fsm_ctrl #(.CNT_W(8)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
    );

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
    function automatic logic [7:0] flags_of(tst_t s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0100;
            S_LP:    return 8'b0000_0101;
            S_FFS:   return 8'b0000_1001;
            S_LAF:   return 8'b0001_0101;
            S_CPE:   return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    function automatic vec_t mk(logic pv, logic [1:0] din, logic ff, logic [2:0] emp,
                                logic [2:0] sr, logic pd, logic lpv, tst_t st,
                                int drop, int abort);
        vec_t v;
        v.pv = pv; v.din = din; v.ff = ff; v.emp = emp; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.st = st; v.drop = drop; v.abort = abort;
        return v;
    endfunction

    function automatic logic [7:0] dut_flags();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge result, then
    // pop and compare once the DUT has clocked.
    task automatic step(vec_t v, string tag);
        vec_t e;
        pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.emp;
        {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
        parity_done = v.pd; low_pkt_valid = v.lpv;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, " flags"}, int'(dut_flags()), int'(flags_of(e.st)));
        check({tag, " drop_cnt"}, int'(drop_cnt), e.drop);
        check({tag, " abort_cnt"}, int'(abort_cnt), e.abort);
    endtask

    initial begin
        // Packet to addr 01, target empty: LFD, LD x4, LP, CPE, DA.
        tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LFD, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LD, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_LP, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_CPE, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b010, 0, 0, 0, S_DA, 0, 0));
        // Soft reset while idle in DECODE_ADDRESS is not an abort.
        tbl.push_back(mk(0, 0, 0, 3'b000, 3'b001, 0, 0, S_DA, 0, 0));
        // Addr 10, FIFO 2 not empty for 5 clocks, then empty.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 2, 0, 3'b000, 0, 0, 0, S_WTE, 0, 0));
        tbl.push_back(mk(1, 2, 0, 3'b100, 0, 0, 0, S_LFD, 0, 0));
        tbl.push_back(mk(1, 2, 0, 3'b100, 0, 0, 0, S_LD, 0, 0));
        tbl.push_back(mk(0, 2, 0, 3'b100, 0, 0, 0, S_LP, 0, 0));
        tbl.push_back(mk(0, 2, 0, 3'b100, 0, 0, 0, S_CPE, 0, 0));
        tbl.push_back(mk(0, 2, 0, 3'b100, 0, 0, 0, S_DA, 0, 0));
        // Full stall 3 clocks, LAF, low_pkt_valid -> LP.
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LAF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 1, S_LP, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 0, 0, S_CPE, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 0, 0, S_DA, 0, 0));
        // parity_done in LAF -> DA (wins over low_pkt_valid).
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LAF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 1, 1, S_DA, 0, 0));
        // LAF with neither -> LD; CPE with fifo_full -> FFS.
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LAF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 0, 0, S_LP, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3'b001, 0, 0, 0, S_CPE, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3'b001, 0, 0, 0, S_FFS, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 0, 0, S_LAF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 0, 1, 0, S_DA, 0, 0));
        // Addr 11 held 6 clocks, twice: one drop per packet.
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DA, 1, 0));
        tbl.push_back(mk(0, 3, 0, 3'b111, 0, 0, 0, S_DA, 1, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 3, 0, 3'b111, 0, 0, 0, S_DA, 2, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0, 0, 0, S_DA, 2, 0));
        // Addr 00: other FIFO's soft reset ignored; own soft reset beats fifo_full.
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 2, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LD, 2, 0));
        tbl.push_back(mk(1, 0, 0, 3'b001, 3'b010, 0, 0, S_LD, 2, 0));
        tbl.push_back(mk(1, 0, 1, 3'b001, 3'b001, 0, 0, S_DA, 2, 1));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0, 0, 0, S_DA, 2, 1));

        // Reset state.
        #12;
        check("reset flags", int'(dut_flags()), int'(flags_of(S_DA)));
        check("reset drop_cnt", int'(drop_cnt), 0);
        check("reset abort_cnt", int'(abort_cnt), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Abort saturation: aborts 2..256 must stop at 8'hFF.
        for (int n = 2; n <= 256; n++) begin
            step(mk(1, 0, 0, 3'b001, 0, 0, 0, S_LFD, 2, n - 1), "sat lfd");
            step(mk(1, 0, 0, 3'b001, 3'b001, 0, 0, S_DA, 2, (n > 255) ? 255 : n), "sat abort");
        end
        step(mk(0, 0, 0, 3'b000, 3'b001, 0, 0, S_DA, 2, 255), "sat idle");

        // Asynchronous reset mid-packet.
        step(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LFD, 2, 255), "pre-rst lfd");
        step(mk(1, 1, 0, 3'b010, 0, 0, 0, S_LD, 2, 255), "pre-rst ld");
        #2;
        resetn = 1'b0;
        #1;
        check("async rst flags", int'(dut_flags()), int'(flags_of(S_DA)));
        check("async rst drop_cnt", int'(drop_cnt), 0);
        check("async rst abort_cnt", int'(abort_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

endmodule
